// File: rtl/term_pkg.sv
// Shared constants and state type for the terminal cursor controller.
package term_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 25;
    localparam int ADDR_W   = 11;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

endpackage

// File: rtl/term_cell_fill.sv
// Writes a run of consecutive text-RAM cells, one per cycle, wrapping at the end of the RAM.
module term_cell_fill
    import term_pkg::*;
#(
    parameter int CELLS = COLS_DEF * ROWS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    logic [ADDR_W-1:0] remaining;

    // The first write is presented the cycle after start; done marks the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            remaining <= '0;
        end else if (start) begin
            wr_en     <= (len != '0);
            wr_addr   <= start_addr;
            remaining <= len;
        end else if (wr_en) begin
            remaining <= remaining - ONE;
            wr_addr   <= (wr_addr == LAST_CELL) ? '0 : wr_addr + ONE;
            if (remaining == ONE) begin
                wr_en <= 1'b0;
            end
        end
    end

    assign done = wr_en && (remaining == ONE);

endmodule

// File: rtl/term_cursor_ctrl.sv
// Cursor, scroll and text-RAM write control for a character terminal.
module term_cursor_ctrl
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        delete,
    input  logic        cuf,
    input  logic        cub,
    input  logic        cnl,
    input  logic        cpl,
    input  logic        cha,
    input  logic        cup,
    input  logic        ed,
    input  logic        el,
    input  logic        su,
    input  logic        sd,
    input  logic        hvp,
    input  logic        scp,
    input  logic        rcp,
    input  logic        clear,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic [4:0]  scroll_top,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CELLS    = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] LINE     = ADDR_W'(COLS);

    state_t            state_q, state_d;
    logic [6:0]        col_q, col_d, sv_col_q, sv_col_d;
    logic [4:0]        row_q, row_d, sv_row_q, sv_row_d, st_q, st_d;
    logic              pend_q, pend_d, swr_q, swr_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [7:0]        sdata_q, sdata_d;
    logic              fill_start, fill_wr, fill_done;
    logic [ADDR_W-1:0] fill_addr, fill_len, fill_wr_addr;

    logic [5:0]        phys_sum;
    logic [4:0]        phys_row, st_inc, st_dec;
    logic [ADDR_W-1:0] cur_addr, log_off;

    assign phys_sum = {1'b0, st_q} + {1'b0, row_q};
    assign phys_row = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];
    assign cur_addr = ADDR_W'(phys_row) * LINE + ADDR_W'(col_q);
    assign log_off  = ADDR_W'(row_q) * LINE + ADDR_W'(col_q);
    assign st_inc   = (st_q == LAST_ROW) ? 5'd0 : st_q + 5'd1;
    assign st_dec   = (st_q == 5'd0) ? LAST_ROW : st_q - 5'd1;

    // A character typed at the bottom-right cell leaves pend_q set; the scroll it
    // owes runs on the next cycle, once the character write has gone out.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        st_d       = st_q;
        sv_col_d   = sv_col_q;
        sv_row_d   = sv_row_q;
        pend_d     = pend_q;
        swr_d      = 1'b0;
        saddr_d    = saddr_q;
        sdata_d    = sdata_q;
        fill_start = 1'b0;
        fill_addr  = cur_addr;
        fill_len   = LINE;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d     = 1'b0;
                    st_d       = st_inc;
                    fill_addr  = ADDR_W'(st_q) * LINE;
                    fill_start = 1'b1;
                end else if (clear) begin
                    st_d       = 5'd0;
                    col_d      = 7'd0;
                    row_d      = 5'd0;
                    fill_addr  = '0;
                    fill_len   = CELLS;
                    fill_start = 1'b1;
                end else if (ed) begin
                    fill_len   = CELLS - log_off;
                    fill_start = 1'b1;
                end else if (el) begin
                    fill_len   = LINE - ADDR_W'(col_q);
                    fill_start = 1'b1;
                end else if (su) begin
                    st_d       = st_inc;
                    fill_addr  = ADDR_W'(st_q) * LINE;
                    fill_start = 1'b1;
                end else if (sd) begin
                    st_d       = st_dec;
                    fill_addr  = ADDR_W'(st_dec) * LINE;
                    fill_start = 1'b1;
                end else if (delete) begin
                    if (col_q != 7'd0) begin
                        col_d   = col_q - 7'd1;
                        swr_d   = 1'b1;
                        saddr_d = cur_addr - ADDR_W'(1);
                        sdata_d = SPACE;
                    end
                end else if (cuf) begin
                    col_d = (col_q == LAST_COL) ? col_q : col_q + 7'd1;
                end else if (cub) begin
                    col_d = (col_q == 7'd0) ? col_q : col_q - 7'd1;
                end else if (cnl) begin
                    row_d = (row_q == LAST_ROW) ? row_q : row_q + 5'd1;
                    col_d = 7'd0;
                end else if (cpl) begin
                    row_d = (row_q == 5'd0) ? row_q : row_q - 5'd1;
                    col_d = 7'd0;
                end else if (cha) begin
                    col_d = 7'd0;
                end else if (cup || hvp) begin
                    row_d = 5'd0;
                    col_d = 7'd0;
                end else if (scp) begin
                    sv_col_d = col_q;
                    sv_row_d = row_q;
                end else if (rcp) begin
                    col_d = sv_col_q;
                    row_d = sv_row_q;
                end else if (char_valid) begin
                    swr_d   = 1'b1;
                    saddr_d = cur_addr;
                    sdata_d = char_in;
                    if (col_q != LAST_COL) begin
                        col_d = col_q + 7'd1;
                    end else begin
                        col_d = 7'd0;
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
                if (fill_start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            st_q     <= '0;
            sv_col_q <= '0;
            sv_row_q <= '0;
            pend_q   <= 1'b0;
            swr_q    <= 1'b0;
            saddr_q  <= '0;
            sdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            st_q     <= st_d;
            sv_col_q <= sv_col_d;
            sv_row_q <= sv_row_d;
            pend_q   <= pend_d;
            swr_q    <= swr_d;
            saddr_q  <= saddr_d;
            sdata_q  <= sdata_d;
        end
    end

    term_cell_fill #(
        .CELLS(COLS * ROWS)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .start     (fill_start),
        .start_addr(fill_addr),
        .len       (fill_len),
        .wr_en     (fill_wr),
        .wr_addr   (fill_wr_addr),
        .done      (fill_done)
    );

    // Single writes and fill sweeps never overlap, so a plain select merges them.
    assign wr_en      = fill_wr | swr_q;
    assign wr_addr    = fill_wr ? fill_wr_addr : saddr_q;
    assign wr_data    = fill_wr ? SPACE : sdata_q;
    assign busy       = (state_q == FILL);
    assign cur_col    = col_q;
    assign cur_row    = row_q;
    assign scroll_top = st_q;

endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Self-checking bench for term_cursor_ctrl: directed scenarios then random commands against a screen model.
module tb_term_cursor_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        delete = 0, cuf = 0, cub = 0, cnl = 0, cpl = 0, cha = 0, cup = 0, ed = 0;
    logic        el = 0, su = 0, sd = 0, hvp = 0, scp = 0, rcp = 0, clear = 0, char_valid = 0;
    logic [7:0]  char_in = 8'h00;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic [4:0]  scroll_top;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    always #5 clk = ~clk;

    term_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .delete(delete), .cuf(cuf), .cub(cub), .cnl(cnl), .cpl(cpl),
        .cha(cha), .cup(cup), .ed(ed), .el(el), .su(su), .sd(sd), .hvp(hvp), .scp(scp),
        .rcp(rcp), .clear(clear), .char_valid(char_valid), .char_in(char_in),
        .cur_col(cur_col), .cur_row(cur_row), .scroll_top(scroll_top), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] dut_ram [CELLS];
    logic [7:0] m_ram [CELLS];
    int m_col = 0, m_row = 0, m_st = 0, m_sc = 0, m_sr = 0;
    int nwr, nbusy, first_wa, last_wa, exp_wr, exp_busy;

    // Op codes: 0 clear, 1 ED, 2 EL, 3 SU, 4 SD, 5 delete, 6 CUF, 7 CUB, 8 CNL,
    // 9 CPL, 10 CHA, 11 CUP, 12 HVP, 13 SCP, 14 RCP, 15 character only.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cellOf(input int r, input int c);
        return ((m_st + r) % ROWS) * COLS + c;
    endfunction

    task automatic fillModel(input int r, input int c, input int n);
        for (int k = 0; k < n; k++) begin
            int idx = r * COLS + c + k;
            m_ram[cellOf(idx / COLS, idx % COLS)] = 8'h20;
        end
    endtask

    task automatic setStrobe(input int op, input logic v);
        case (op)
            0: clear = v;   1: ed = v;   2: el = v;   3: su = v;   4: sd = v;
            5: delete = v;  6: cuf = v;  7: cub = v;  8: cnl = v;  9: cpl = v;
            10: cha = v;    11: cup = v; 12: hvp = v; 13: scp = v; 14: rcp = v;
            15: char_valid = v;
            default: ;
        endcase
    endtask

    task automatic modelStep(input int op, input logic [7:0] ch);
        int n;
        exp_wr = 0;
        exp_busy = 0;
        case (op)
            0: begin m_st = 0; m_col = 0; m_row = 0; fillModel(0, 0, CELLS); exp_wr = CELLS; end
            1: begin n = CELLS - (m_row * COLS + m_col); fillModel(m_row, m_col, n); exp_wr = n; end
            2: begin n = COLS - m_col; fillModel(m_row, m_col, n); exp_wr = n; end
            3: begin m_st = (m_st + 1) % ROWS; fillModel(ROWS - 1, 0, COLS); exp_wr = COLS; end
            4: begin m_st = (m_st + ROWS - 1) % ROWS; fillModel(0, 0, COLS); exp_wr = COLS; end
            5: if (m_col > 0) begin m_col--; m_ram[cellOf(m_row, m_col)] = 8'h20; exp_wr = 1; end
            6: if (m_col < COLS - 1) m_col++;
            7: if (m_col > 0) m_col--;
            8: begin if (m_row < ROWS - 1) m_row++; m_col = 0; end
            9: begin if (m_row > 0) m_row--; m_col = 0; end
            10: m_col = 0;
            11, 12: begin m_row = 0; m_col = 0; end
            13: begin m_sc = m_col; m_sr = m_row; end
            14: begin m_col = m_sc; m_row = m_sr; end
            default: begin
                m_ram[cellOf(m_row, m_col)] = ch;
                exp_wr = 1;
                if (m_col < COLS - 1) m_col++;
                else begin
                    m_col = 0;
                    if (m_row < ROWS - 1) m_row++;
                    else begin
                        m_st = (m_st + 1) % ROWS;
                        fillModel(ROWS - 1, 0, COLS);
                        exp_wr += COLS;
                        exp_busy = COLS;
                    end
                end
            end
        endcase
        if (op <= 4) exp_busy = exp_wr;
    endtask

    task automatic checkRam();
        int m = 0;
        for (int i = 0; i < CELLS; i++) if (dut_ram[i] !== m_ram[i]) m++;
        checkOutput("ram", m, 0);
    endtask

    // Entered and left at a falling edge; one command per call, then waits for it to settle.
    task automatic applyStimulus(input int op, input logic [7:0] ch, input logic extra_char, input int inject);
        bit done = 0;
        char_in = ch;
        setStrobe(op, 1'b1);
        if (extra_char) char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        setStrobe(op, 1'b0);
        char_valid = 1'b0;
        modelStep(op, ch);
        nwr = 0;
        nbusy = 0;
        for (int i = 0; i < CELLS + 200 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (wr_en) begin
                if (nwr == 0) first_wa = wr_addr;
                last_wa = wr_addr;
                dut_ram[wr_addr] = wr_data;
                nwr++;
            end
            if (busy) nbusy++;
            if (!wr_en && !busy) done = 1;
            if (i == 4 && inject >= 0) setStrobe(inject, 1'b0);
            if (i == 3 && inject >= 0) setStrobe(inject, 1'b1);
        end
        checkOutput("settle", done, 1);
        checkOutput("col", cur_col, m_col);
        checkOutput("row", cur_row, m_row);
        checkOutput("scroll", scroll_top, m_st);
        checkOutput("writes", nwr, exp_wr);
        checkOutput("busy_cycles", nbusy, exp_busy);
        checkRam();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int op, r;
        for (int i = 0; i < CELLS; i++) begin
            dut_ram[i] = 8'h00;
            m_ram[i] = 8'h00;
        end
        #12;
        checkOutput("rst_col", cur_col, 0);
        checkOutput("rst_row", cur_row, 0);
        checkOutput("rst_scroll", scroll_top, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] CUB at home");
        applyStimulus(7, 8'h00, 1'b0, -1);
        checkOutput("cub_home_writes", nwr, 0);

        $display("[TB] one line of A");
        repeat (80) applyStimulus(15, 8'h41, 1'b0, -1);
        checkOutput("line_row", cur_row, 1);
        checkOutput("line_col", cur_col, 0);

        $display("[TB] character at bottom-right scrolls");
        repeat (24) applyStimulus(8, 8'h00, 1'b0, -1);
        repeat (79) applyStimulus(6, 8'h00, 1'b0, -1);
        applyStimulus(15, 8'h42, 1'b0, -1);
        checkOutput("br_first_addr", first_wa, 1999);
        checkOutput("br_last_addr", last_wa, 79);
        checkOutput("br_busy", nbusy, 80);
        checkOutput("br_scroll", scroll_top, 1);
        checkOutput("br_row", cur_row, 24);
        checkOutput("br_col", cur_col, 0);

        $display("[TB] erase in line with CUF while busy");
        applyStimulus(0, 8'h00, 1'b0, -1);
        repeat (3) applyStimulus(8, 8'h00, 1'b0, -1);
        repeat (10) applyStimulus(6, 8'h00, 1'b0, -1);
        applyStimulus(2, 8'h00, 1'b0, 6);
        checkOutput("el_first_addr", first_wa, 250);
        checkOutput("el_last_addr", last_wa, 319);
        checkOutput("el_busy", nbusy, 70);
        checkOutput("el_col", cur_col, 10);

        $display("[TB] save and restore cursor, clear");
        applyStimulus(11, 8'h00, 1'b0, -1);
        repeat (5) applyStimulus(8, 8'h00, 1'b0, -1);
        repeat (5) applyStimulus(6, 8'h00, 1'b0, -1);
        applyStimulus(13, 8'h00, 1'b0, -1);
        applyStimulus(11, 8'h00, 1'b0, -1);
        checkOutput("cup_col", cur_col, 0);
        applyStimulus(14, 8'h00, 1'b0, -1);
        checkOutput("rcp_row", cur_row, 5);
        checkOutput("rcp_col", cur_col, 5);
        applyStimulus(3, 8'h00, 1'b0, -1);
        applyStimulus(0, 8'h00, 1'b0, -1);
        checkOutput("clear_writes", nwr, 2000);
        checkOutput("clear_scroll", scroll_top, 0);

        $display("[TB] reset during clear");
        repeat (2) applyStimulus(8, 8'h00, 1'b0, -1);
        repeat (2) applyStimulus(6, 8'h00, 1'b0, -1);
        applyStimulus(13, 8'h00, 1'b0, -1);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        repeat (499) @(negedge clk);
        checkOutput("mid_clear_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_wr_en", wr_en, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_col", cur_col, 0);
        checkOutput("abort_row", cur_row, 0);
        checkOutput("abort_wr_addr", wr_addr, 0);
        checkOutput("abort_wr_data", wr_data, 0);
        m_col = 0; m_row = 0; m_st = 0; m_sc = 0; m_sr = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8, 8'h00, 1'b0, -1);
        applyStimulus(14, 8'h00, 1'b0, -1);
        checkOutput("rcp_unsaved_row", cur_row, 0);
        applyStimulus(0, 8'h00, 1'b0, -1);

        $display("[TB] random commands");
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) op = 15;
            else if (r < 50) op = 5;
            else if (r < 51) op = 0;
            else if (r < 52) op = 1;
            else if (r < 55) op = 2;
            else if (r < 59) op = 3;
            else if (r < 63) op = 4;
            else if (r < 91) op = $urandom_range(6, 12);
            else if (r < 96) op = 13;
            else op = 14;
            applyStimulus(op, 8'($urandom_range(33, 126)),
                          (op < 15) && ($urandom_range(0, 3) == 0), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
